// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial pattern detector.
package seq_det_pkg;

  // Widest pattern the detector is meant to be built with.
  localparam int PAT_LEN_MAX = 16;

  // Pattern register value after reset (all-ones, sliced to PAT_LEN).
  localparam logic [PAT_LEN_MAX-1:0] PAT_RESET = '1;

  // Width needed to count 0..pat_len valid history bits.
  function automatic int fill_width(input int pat_len);
    return $clog2(pat_len + 1);
  endfunction

endpackage

// File: rtl/seq_shift_hist.sv
// Serial shift history plus saturating fill counter for seq_pattern_detector.
// Newest bit enters at the LSB. The next-state values go back to the top level,
// so the match compare sees the history including the bit being sampled now.
module seq_shift_hist #(
  parameter int PAT_LEN = 4,
  parameter int FILL_W  = 3
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               w,
  input  logic               sample,     // take w on this edge
  input  logic               load,       // pattern reload: clear history and fill
  input  logic               restart,    // non-overlap match: restart fill, keep history
  output logic [FILL_W-1:0]  fill,
  output logic [PAT_LEN-1:0] hist_next,
  output logic [FILL_W-1:0]  fill_next
);

  logic [PAT_LEN-1:0] hist;

  assign hist_next = {hist[PAT_LEN-2:0], w};
  assign fill_next = (fill == FILL_W'(PAT_LEN)) ? fill : fill + FILL_W'(1);

  // History and fill update: load clears, a sample shifts in w and advances fill.
  // NOTE: sequential state uses non-blocking assignments so every register sees
  // the pre-edge values of its neighbours, whatever order the statements are in.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      hist <= '0;
      fill <= '0;
    end else if (load) begin
      hist <= '0;
      fill <= '0;
    end else if (sample) begin
      hist <= hist_next;
      fill <= restart ? '0 : fill_next;
    end
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// Run-time loadable serial pattern detector with overlap control, a registered
// one-cycle match pulse and a saturating match counter.
// Optional feature: define SEQDET_MASK_EN to add a care_mask input; only bits
// with mask_q=1 take part in the compare.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter  int PAT_LEN = 4,
  parameter  int CNT_W   = 8,
  localparam int FILL_W  = fill_width(PAT_LEN)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               w,
  input  logic               w_valid,
  input  logic               load,
  input  logic [PAT_LEN-1:0] pattern,
`ifdef SEQDET_MASK_EN
  input  logic [PAT_LEN-1:0] care_mask,
`endif
  input  logic               overlap,
  input  logic               clr_count,
  output logic               z,
  output logic [FILL_W-1:0]  fill,
  output logic [CNT_W-1:0]   match_count,
  output logic [PAT_LEN-1:0] pat_q
);

  logic [PAT_LEN-1:0] hist_next;
  logic [FILL_W-1:0]  fill_next;
  logic               sample;
  logic               full;
  logic               equal;
  logic               match;
  logic               restart;

  // A load in the same cycle swallows the sample, so it can never match.
  assign sample  = w_valid & ~load;
  assign full    = (fill_next == FILL_W'(PAT_LEN));
  assign match   = sample & full & equal;
  assign restart = match & ~overlap;

`ifdef SEQDET_MASK_EN
  logic [PAT_LEN-1:0] mask_q;

  assign equal = (((hist_next ^ pat_q) & mask_q) == '0);

  // Care mask register, captured alongside the pattern.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      mask_q <= '1;
    end else if (load) begin
      mask_q <= care_mask;
    end
  end
`else
  assign equal = (hist_next == pat_q);
`endif

  seq_shift_hist #(
    .PAT_LEN (PAT_LEN),
    .FILL_W  (FILL_W)
  ) u_hist (
    .clock     (clock),
    .reset_n   (reset_n),
    .w         (w),
    .sample    (sample),
    .load      (load),
    .restart   (restart),
    .fill      (fill),
    .hist_next (hist_next),
    .fill_next (fill_next)
  );

  // Pattern register, reloaded on load and restored to all-ones by reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pat_q <= PAT_RESET[PAT_LEN-1:0];
    end else if (load) begin
      pat_q <= pattern;
    end
  end

  // Registered match pulse: high for exactly the cycle after a matching sample.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      z <= 1'b0;
    end else begin
      z <= match;
    end
  end

  // Saturating match counter; a clear wins over a simultaneous increment.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      match_count <= '0;
    end else if (clr_count) begin
      match_count <= '0;
    end else if (match && (match_count != '1)) begin
      match_count <= match_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Self-checking bench for seq_pattern_detector (PAT_LEN=4). A second instance
// with CNT_W=2 shares all inputs to exercise counter saturation. A reference
// model pushes the expected outputs for every clock into a scoreboard queue;
// each entry is popped and compared just after the edge it describes.
module tb_seq_pattern_detector;

  localparam int PAT_LEN = 4;
  localparam int FILL_W  = 3;

  typedef struct {
    logic               z;
    logic [FILL_W-1:0]  fill;
    logic [7:0]         cnt;
    logic [1:0]         cnt_sat;
    logic [PAT_LEN-1:0] pat;
  } exp_t;

  logic               clock = 1'b0;
  logic               reset_n = 1'b1;
  logic               w = 1'b0;
  logic               w_valid = 1'b0;
  logic               load = 1'b0;
  logic [PAT_LEN-1:0] pattern = '0;
  logic [PAT_LEN-1:0] care_mask = '1;
  logic               overlap = 1'b1;
  logic               clr_count = 1'b0;

  logic               z, z_sat;
  logic [FILL_W-1:0]  fill, fill_sat;
  logic [7:0]         match_count;
  logic [1:0]         match_count_sat;
  logic [PAT_LEN-1:0] pat_q, pat_q_sat;

  int vectors = 0;
  int miscompares = 0;
  int z_seen = 0;

  exp_t sb_q[$];

  // Reference model state.
  logic [PAT_LEN-1:0] m_hist, m_pat, m_mask;
  logic [FILL_W-1:0]  m_fill;
  logic [7:0]         m_cnt;
  logic [1:0]         m_cnt_sat;

  seq_pattern_detector #(.PAT_LEN(PAT_LEN), .CNT_W(8)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .w           (w),
    .w_valid     (w_valid),
    .load        (load),
    .pattern     (pattern),
`ifdef SEQDET_MASK_EN
    .care_mask   (care_mask),
`endif
    .overlap     (overlap),
    .clr_count   (clr_count),
    .z           (z),
    .fill        (fill),
    .match_count (match_count),
    .pat_q       (pat_q)
  );

  seq_pattern_detector #(.PAT_LEN(PAT_LEN), .CNT_W(2)) dut_sat (
    .clock       (clock),
    .reset_n     (reset_n),
    .w           (w),
    .w_valid     (w_valid),
    .load        (load),
    .pattern     (pattern),
`ifdef SEQDET_MASK_EN
    .care_mask   (care_mask),
`endif
    .overlap     (overlap),
    .clr_count   (clr_count),
    .z           (z_sat),
    .fill        (fill_sat),
    .match_count (match_count_sat),
    .pat_q       (pat_q_sat)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Model the edge for the current inputs, push the prediction, clock, then
  // pop and compare. Entered and left at a falling edge; inputs return to idle.
  task automatic tick();
    exp_t e;
    exp_t got;
    logic [PAT_LEN-1:0] hn;
    logic [FILL_W-1:0]  fn;
    logic               mz;
    mz = 1'b0;
    if (!reset_n) begin
      m_hist = '0; m_fill = '0; m_pat = '1; m_mask = '1; m_cnt = '0; m_cnt_sat = '0;
    end else begin
      if (load) begin
        m_pat  = pattern;
`ifdef SEQDET_MASK_EN
        m_mask = care_mask;
`endif
        m_hist = '0;
        m_fill = '0;
      end else if (w_valid) begin
        hn = {m_hist[PAT_LEN-2:0], w};
        fn = (m_fill == FILL_W'(PAT_LEN)) ? m_fill : m_fill + 1'b1;
        mz = (fn == FILL_W'(PAT_LEN)) && (((hn ^ m_pat) & m_mask) == '0);
        m_hist = hn;
        m_fill = (mz && !overlap) ? '0 : fn;
      end
      if (clr_count) begin
        m_cnt = '0; m_cnt_sat = '0;
      end else if (mz) begin
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 1'b1;
        if (m_cnt_sat != 2'b11) m_cnt_sat = m_cnt_sat + 1'b1;
      end
    end
    e.z = mz; e.fill = m_fill; e.cnt = m_cnt; e.cnt_sat = m_cnt_sat; e.pat = m_pat;
    sb_q.push_back(e);

    @(posedge clock);
    #1;
    got = sb_q.pop_front();
    check("z", 32'(z), 32'(got.z));
    check("fill", 32'(fill), 32'(got.fill));
    check("match_count", 32'(match_count), 32'(got.cnt));
    check("match_count_sat", 32'(match_count_sat), 32'(got.cnt_sat));
    check("pat_q", 32'(pat_q), 32'(got.pat));
    if (z) z_seen++;

    @(negedge clock);
    reset_n = 1'b1; w_valid = 1'b0; load = 1'b0; clr_count = 1'b0; w = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
  endtask

  task automatic sample_bit(input logic b);
    w_valid = 1'b1;
    w = b;
    tick();
  endtask

  task automatic idle();
    tick();
  endtask

  task automatic load_pat(input logic [PAT_LEN-1:0] p, input logic [PAT_LEN-1:0] m, input logic clr);
    load = 1'b1;
    pattern = p;
    care_mask = m;
    clr_count = clr;
    tick();
  endtask

  // Send the low n bits of bits, MSB first, optionally with an idle gap after each.
  task automatic send(input logic [15:0] bits, input int n, input logic gap);
    logic [15:0] v;
    v = bits;
    for (int i = n - 1; i >= 0; i--) begin
      sample_bit(v[i]);
      if (gap) idle();
    end
  endtask

  initial begin
    @(negedge clock);

    // Reset state and default all-ones pattern with overlap.
    do_reset();
    check("rst_pat_q", 32'(pat_q), 32'hF);
    check("rst_fill", 32'(fill), 32'd0);
    check("rst_count", 32'(match_count), 32'd0);
    check("rst_z", 32'(z), 32'd0);
    overlap = 1'b1;
    z_seen = 0;
    send(16'h003F, 6, 1'b0);
    check("ones_pulses", 32'(z_seen), 32'd3);
    check("ones_count", 32'(match_count), 32'd3);
    check("ones_fill", 32'(fill), 32'd4);

    // Non-overlapping 1101 over 1101101: one match.
    load_pat(4'b1101, 4'hF, 1'b1);
    overlap = 1'b0;
    z_seen = 0;
    send(16'b1101101, 7, 1'b0);
    check("nonovl_count", 32'(match_count), 32'd1);
    check("nonovl_pulses", 32'(z_seen), 32'd1);

    // Overlapping: matches after bits 4 and 7.
    load_pat(4'b1101, 4'hF, 1'b1);
    overlap = 1'b1;
    z_seen = 0;
    send(16'b1101101, 7, 1'b0);
    check("ovl_count", 32'(match_count), 32'd2);
    check("ovl_pulses", 32'(z_seen), 32'd2);

    // Same stream with idle cycles between bits; fill holds over gaps.
    load_pat(4'b1101, 4'hF, 1'b1);
    z_seen = 0;
    send(16'b1101101, 7, 1'b1);
    check("gap_count", 32'(match_count), 32'd2);
    check("gap_pulses", 32'(z_seen), 32'd2);
    check("gap_fill_hold", 32'(fill), 32'd4);

    // Load with a simultaneous valid sample discards the sample.
    load_pat(4'b1101, 4'hF, 1'b1);
    send(16'b110, 3, 1'b0);
    check("pre_load_fill", 32'(fill), 32'd3);
    w_valid = 1'b1;
    w = 1'b1;
    load_pat(4'b1101, 4'hF, 1'b0);
    check("load_fill", 32'(fill), 32'd0);
    check("load_z", 32'(z), 32'd0);
    z_seen = 0;
    send(16'b110, 3, 1'b0);
    check("load_no_early", 32'(z_seen), 32'd0);
    sample_bit(1'b1);
    check("load_match_z", 32'(z), 32'd1);
    check("load_count", 32'(match_count), 32'd1);

    // Counter saturation on the 2-bit instance; clear beats a simultaneous match.
    do_reset();
    overlap = 1'b1;
    send(16'h00FF, 8, 1'b0);
    check("sat_count2", 32'(match_count_sat), 32'd3);
    check("sat_count8", 32'(match_count), 32'd5);
    clr_count = 1'b1;
    sample_bit(1'b1);
    check("clr_match_z", 32'(z), 32'd1);
    check("clr_count", 32'(match_count), 32'd0);
    check("clr_count2", 32'(match_count_sat), 32'd0);

    // Overlap change mid-stream applies from the next match.
    load_pat(4'b1111, 4'hF, 1'b1);
    overlap = 1'b1;
    send(16'hF, 4, 1'b0);
    overlap = 1'b0;
    sample_bit(1'b1);
    check("ovl_switch_fill", 32'(fill), 32'd0);
    send(16'h7, 3, 1'b0);
    check("ovl_switch_count", 32'(match_count), 32'd2);

    // Reset mid-stream discards history and pattern.
    load_pat(4'b0110, 4'hF, 1'b1);
    send(16'b011, 3, 1'b0);
    check("mid_fill", 32'(fill), 32'd3);
    do_reset();
    check("mid_rst_fill", 32'(fill), 32'd0);
    check("mid_rst_z", 32'(z), 32'd0);
    check("mid_rst_count", 32'(match_count), 32'd0);
    check("mid_rst_pat", 32'(pat_q), 32'hF);

`ifdef SEQDET_MASK_EN
    // Masked compare: only the outer bits of 1001 matter.
    load_pat(4'b1001, 4'b1001, 1'b1);
    z_seen = 0;
    send(16'hF, 4, 1'b0);
    check("mask_pulses", 32'(z_seen), 32'd1);
`endif

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
